// File: rtl/axis_bram_stream_reader_if.sv
// AXI4-Stream master bundle for the ring-buffer reader.
// Valid/ready: a word transfers on a cycle where tvalid && tready; once tvalid rises, tdata/tlast/tvalid hold until that transfer.
interface axis_bram_stream_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_stream_reader.sv
// Drains a BRAM ring buffer via port B into an AXI4-Stream with per-block tlast and a sticky overrun flag.
// Optional fill monitor outputs (fill_level, fill_max) under AXIS_BRAM_STREAM_READER_FILL_MON_EN.
module axis_bram_stream_reader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int BLOCK_LEN = 256
) (
  input  logic                   a_clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   resync,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   wr_lap,
  output logic                   BRAM_PORTB_clk,
  output logic [ADDR_W-1:0]      BRAM_PORTB_addr,
  output logic                   BRAM_PORTB_en,
  input  logic [DATA_W-1:0]      BRAM_PORTB_dout,
  axis_bram_stream_reader_if.master M_AXIS,
  output logic                   overrun,
  output logic [31:0]            words_read,
`ifdef AXIS_BRAM_STREAM_READER_FILL_MON_EN
  output logic [ADDR_W:0]        fill_level,
  output logic [ADDR_W:0]        fill_max,
`endif
  output logic [1:0]             o_dbg_state
);

  localparam int BLK_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLOCK_LEN - 1);
  localparam logic [ADDR_W:0]   FILL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_OVR   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_lap;
  logic [ADDR_W:0]     r_fill;
  logic [ADDR_W:0]     w_wr_ptr, w_rd_ptr_nx;
  logic [RD_LAT-1:0]   r_inflight;
  logic [2:0]          w_inflight_cnt;
  logic [DATA_W-1:0]   r_fifo [4];
  logic [1:0]          r_wp, r_rp;
  logic [2:0]          r_count;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic [31:0]         r_words_read;
  logic                w_flush, w_issue, w_push, w_pop, w_tvalid;

  assign w_flush  = restart | resync;
  assign w_wr_ptr = {wr_lap, wr_addr};
  assign w_tvalid = (r_count != 3'd0) && (r_state != ST_FLUSH);
  assign w_pop    = w_tvalid && M_AXIS.tready;
  assign w_push   = r_inflight[RD_LAT-1] && !w_flush;

  always_comb begin
    w_inflight_cnt = 3'd0;
    for (int i = 0; i < RD_LAT; i++) w_inflight_cnt = w_inflight_cnt + {2'b00, r_inflight[i]};
  end

  // A stale fill above the ring depth means data is already overwritten; never fetch it.
  assign w_issue = (r_state == ST_RUN) && !w_flush && (r_fill != '0) &&
                   (r_fill <= FILL_DEPTH) && ((r_count + w_inflight_cnt) < 3'd4);

  // Fill is registered against the post-issue pointer so it never lags our own reads.
  always_comb begin
    w_rd_ptr_nx = {r_rd_lap, r_rd_addr};
    if (restart)      w_rd_ptr_nx = '0;
    else if (resync)  w_rd_ptr_nx = w_wr_ptr;
    else if (w_issue) w_rd_ptr_nx = {r_rd_lap, r_rd_addr} + 1'b1;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_flush) begin
      w_state_nx = ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN:   if (r_fill > FILL_DEPTH) w_state_nx = ST_OVR;
        ST_OVR:   w_state_nx = ST_OVR;
        ST_FLUSH: w_state_nx = ST_RUN;
        default:  w_state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge a_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_rd_addr    <= '0;
      r_rd_lap     <= 1'b0;
      r_fill       <= '0;
      r_inflight   <= '0;
      r_wp         <= 2'd0;
      r_rp         <= 2'd0;
      r_count      <= 3'd0;
      r_blk_cnt    <= '0;
      r_words_read <= '0;
    end else begin
      r_state               <= w_state_nx;
      {r_rd_lap, r_rd_addr} <= w_rd_ptr_nx;
      r_fill                <= w_wr_ptr - w_rd_ptr_nx;
      if (w_flush) begin
        r_inflight <= '0;
        r_wp       <= 2'd0;
        r_rp       <= 2'd0;
        r_count    <= 3'd0;
      end else begin
        r_inflight[0] <= w_issue;
        for (int i = 1; i < RD_LAT; i++) r_inflight[i] <= r_inflight[i-1];
        if (w_push) r_wp <= r_wp + 2'd1;
        if (w_pop)  r_rp <= r_rp + 2'd1;
        r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
      end
      // A transfer coinciding with restart/resync still counts before the flush.
      if (w_pop) r_words_read <= r_words_read + 32'd1;
      if (restart)    r_blk_cnt <= '0;
      else if (w_pop) r_blk_cnt <= (r_blk_cnt == BLK_LAST) ? '0 : r_blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge a_clk) begin
    if (w_push) r_fifo[r_wp] <= BRAM_PORTB_dout;
  end

`ifdef AXIS_BRAM_STREAM_READER_FILL_MON_EN
  logic [ADDR_W:0] r_fill_max;
  always_ff @(posedge a_clk or posedge reset) begin
    if (reset)                   r_fill_max <= '0;
    else if (restart)            r_fill_max <= '0;
    else if (r_fill > r_fill_max) r_fill_max <= r_fill;
  end
  assign fill_level = r_fill;
  assign fill_max   = r_fill_max;
`endif

  assign BRAM_PORTB_clk  = a_clk;
  assign BRAM_PORTB_addr = r_rd_addr;
  assign BRAM_PORTB_en   = w_issue;
  assign M_AXIS.tdata    = r_fifo[r_rp];
  assign M_AXIS.tvalid   = w_tvalid;
  assign M_AXIS.tlast    = w_tvalid && (r_blk_cnt == BLK_LAST);
  assign overrun         = (r_state == ST_OVR);
  assign words_read      = r_words_read;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/axis_bram_stream_reader.md
Name: axis_bram_stream_reader

Overview:
- Drains the GVP data-stream ring buffer (16384 x 32 BRAM) through port B and presents the words as an AXI4-Stream.
- Port A of the same BRAM is filled by the stream-source writer.
- The reader tracks the writer's address and lap bit, and emits tlast every BLOCK_LEN words.
- It flags a sticky overrun when the writer laps it. It sits between the BRAM and the host DMA/PS transfer path.

Parameters:
- ADDR_W, 14, BRAM word-address width; ring depth = 2^ADDR_W.
- DATA_W, 32, BRAM/stream word width.
- RD_LAT, 1, BRAM port-B read latency in cycles (1 or 2).
- BLOCK_LEN, 256, words per stream block; tlast on the last word of each block.

Ports:
- a_clk  in  1  sole clock; BRAM port B and stream are synchronous to it
- reset  in  1  asynchronous, active-high; clears all state
- restart  in  1  sync pulse; rd pointer, lap, block count, overrun, FIFO := 0
- resync  in  1  sync pulse; rd pointer/lap := writer pointer/lap, FIFO flushed, overrun cleared
- wr_addr  in  ADDR_W  writer next-write address (static over >=2 a_clk)
- wr_lap  in  1  writer lap bit, toggles on each address wrap
- BRAM_PORTB_clk  out  1  = a_clk
- BRAM_PORTB_addr  out  ADDR_W  read address
- BRAM_PORTB_en  out  1  read strobe, one word per asserted cycle
- BRAM_PORTB_dout  in  DATA_W  read data, valid RD_LAT cycles after en
- M_AXIS_tdata  out  DATA_W  stream data
- M_AXIS_tvalid  out  1  stream valid
- M_AXIS_tlast  out  1  block end
- M_AXIS_tready  in  1  downstream ready
- overrun  out  1  sticky writer-lapped-reader flag
- words_read  out  32  transferred-word counter, wraps

Behaviour:
- Reset values:
  - tvalid, tlast, BRAM_PORTB_en, overrun = 0
  - BRAM_PORTB_addr = 0, words_read = 0
  - rd pointer = 0, lap = 0, FIFO empty, block count = 0
- Fill level: fill = {wr_lap,wr_addr} - {rd_lap,rd_addr}, computed modulo 2^(ADDR_W+1), registered once. Empty when fill == 0.
- Overrun: if fill > 2^ADDR_W, overrun := 1 the next cycle.
  - While overrun is set, no new reads are issued.
  - Words already in the FIFO still drain.
  - Only restart, resync or reset clears it.
- Read issue:
  - BRAM_PORTB_en = 1 when fill != 0, !overrun, and (fifo_count + inflight) < 4.
  - On issue, rd_addr increments. Wrap from 2^ADDR_W-1 to 0 toggles rd_lap.
- In-flight tracking: a RD_LAT-deep valid shift register. Its output writes dout into a 4-entry output FIFO, so the FIFO can never overflow.
- Stream handshake:
  - tvalid = FIFO not empty; tdata = FIFO head.
  - A transfer occurs on tvalid & tready. It pops the FIFO, increments words_read and advances the block count.
  - tdata and tvalid are stable while tvalid & !tready.
- tlast is 1 on the head word when block count == BLOCK_LEN-1. Block count wraps to 0 on that transfer.
- Throughput: sustains one word per cycle with tready held high. First word latency from fill becoming nonzero is RD_LAT+2 cycles (fill register, issue, RD_LAT).
- State machine:
  - RUN: normal.
  - OVR: overrun; drain only.
  - FLUSH: one cycle on restart/resync. tvalid is forced to 0, the FIFO is emptied, in-flight words are discarded, then the machine goes to RUN.
- Priority: reset > restart > resync > normal. A resync in the same cycle as a transfer counts the transfer, then flushes.
- Reset mid-operation: immediate asynchronous clear. A partial block is discarded; the next block count restarts at 0.

Optional Feature:
- Macro: AXIS_BRAM_STREAM_READER_FILL_MON_EN
- Defined: adds output fill_level [ADDR_W:0] (registered fill) and output fill_max [ADDR_W:0]. fill_max is a high-watermark of fill_level, cleared by reset and restart.
- Undefined: both ports are absent, with no watermark logic; all other behaviour is identical.

Test Plan:
- Basic drain: preload BRAM[0..9] = 100..109, wr_addr 0 -> 10, tready = 1 -> 10 words 100..109 on consecutive cycles; words_read = 10; tlast = 0; BRAM_PORTB_en deasserts once rd_addr = 10.
- Block/tlast, BLOCK_LEN = 4: 9 words -> tlast on transfers 4 and 8 only; block count = 1 at the end.
- Backpressure: 6 words with tready toggling 1,0,0,1,... -> no word lost or duplicated; tdata stable across stall cycles; FIFO never exceeds 4; en stalls when count + inflight = 4.
- Wrap-around, ADDR_W = 4: start rd = wr = 14, write 6 words (wr_addr 4, wr_lap 1) -> reads addresses 14,15,0,1,2,3 in order; rd_lap = 1; no overrun.
- Overrun, ADDR_W = 4: reader stalled at rd = 0/lap 0, writer advances to addr 1/lap 1 (fill = 17) -> overrun = 1; en stays 0; resync clears it and reading resumes at addr 1.
- Reset/restart mid-stream: assert reset while 3 words are buffered -> tvalid = 0 the same cycle, words_read = 0. Then restart with wr_addr = 2 -> reads BRAM[0], BRAM[1] only.
